// File: rtl/shift_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_cmd_sequencer_if : command, shifter and result signals of the sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface shift_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic [2:0] cmd_amt;
   logic       cmd_dir;

   logic [7:0] sh_a_out;
   logic [2:0] sh_amt_out;
   logic       sh_sel_out;
   logic [7:0] sh_result_in;

   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;

   modport slave (
      input  cmd_valid, cmd_data, cmd_amt, cmd_dir, sh_result_in, res_ready,
      output cmd_ready, sh_a_out, sh_amt_out, sh_sel_out, res_valid, res_data
   );

   modport master (
      output cmd_valid, cmd_data, cmd_amt, cmd_dir, sh_result_in, res_ready,
      input  cmd_ready, sh_a_out, sh_amt_out, sh_sel_out, res_valid, res_data
   );
endinterface

`default_nettype wire

// File: rtl/shift_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// shift_cmd_sequencer : FIFO-buffered register front/back end for an 8-bit rotator.
// Optional result counter enabled by SHIFT_CMD_SEQ_COUNT_EN.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_cmd_sequencer #(
   parameter int FIFO_AW = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   shift_cmd_sequencer_if.slave  bus
`ifdef SHIFT_CMD_SEQ_COUNT_EN
   ,
   output logic [15:0]           res_count
`endif
);

   localparam int              DEPTH      = 1 << FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
   localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW:0]   CNT_FULL = CNT_ONE << FIFO_AW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [11:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;

   logic [7:0] sh_a_q;
   logic [2:0] sh_amt_q;
   logic       sh_sel_q;
   logic       res_valid_q;
   logic [7:0] res_data_q;

   logic fifo_empty;
   logic cmd_ready;
   logic push;
   logic pop;
   logic capture;
   logic release_out;

   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = (count_q != CNT_FULL);
   assign push       = bus.cmd_valid && cmd_ready;

   assign bus.cmd_ready  = cmd_ready;
   assign bus.sh_a_out   = sh_a_q;
   assign bus.sh_amt_out = sh_amt_q;
   assign bus.sh_sel_out = sh_sel_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_data   = res_data_q;

   // Pops look at the registered count, so a same-cycle push is not yet visible.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      capture     = 1'b0;
      release_out = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            capture = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            if (bus.res_ready) begin
               release_out = 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {bus.cmd_dir, bus.cmd_amt, bus.cmd_data};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_a_q      <= '0;
         sh_amt_q    <= '0;
         sh_sel_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         if (pop) begin
            {sh_sel_q, sh_amt_q, sh_a_q} <= mem[rd_ptr_q];
         end
         if (capture) begin
            res_data_q  <= bus.sh_result_in;
            res_valid_q <= 1'b1;
         end else if (release_out) begin
            res_valid_q <= 1'b0;
         end
      end
   end

`ifdef SHIFT_CMD_SEQ_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         res_count <= '0;
      end else if (res_valid_q && bus.res_ready && (res_count != 16'hFFFF)) begin
         res_count <= res_count + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire
